// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the time-multiplexed FIR filter:
// controller states, accumulator sizing and the round/saturate output stage.
package fir_pkg;

   typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

   localparam int RS_W = 64;
   localparam logic signed [RS_W-1:0] RS_ONE = 1;

   typedef struct packed {
      logic                   sat;
      logic signed [RS_W-1:0] value;
   } rs_t;

   function automatic int acc_width(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

   // Round half up, arithmetic shift, then clamp to the signed out_w range.
   function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc,
                                     input int shift, input int out_w);
      logic signed [RS_W-1:0] rounded;
      logic signed [RS_W-1:0] hi;
      logic signed [RS_W-1:0] lo;
      rs_t r;
      rounded = acc;
      if (shift > 0) begin
         rounded = (acc + (RS_ONE <<< (shift - 1))) >>> shift;
      end
      hi = (RS_ONE <<< (out_w - 1)) - RS_ONE;
      lo = -(RS_ONE <<< (out_w - 1));
      r.sat   = 1'b0;
      r.value = rounded;
      if (rounded > hi) begin
         r.sat   = 1'b1;
         r.value = hi;
      end else if (rounded < lo) begin
         r.sat   = 1'b1;
         r.value = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_filter_mac_mac.sv
// Registered multiply-accumulate with synchronous clear and enable; also exposes
// the sum the accumulator would take this edge so the caller can act on it early.
module fir_mac
   import fir_pkg::*;
#(
   parameter int A_W   = 8,
   parameter int B_W   = 8,
   parameter int ACC_W = 18
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [A_W-1:0]   a,
   input  logic signed [B_W-1:0]   b,
   output logic signed [ACC_W-1:0] acc_next
);

   localparam int P_W = A_W + B_W;

   logic signed [P_W-1:0]   prod;
   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;

   always_comb begin
      prod     = a * b;
      acc_next = acc_q + {{(ACC_W - P_W){prod[P_W-1]}}, prod};
      acc_d    = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = acc_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/fir_filter_mac.sv
// Time-multiplexed FIR: one MAC walks all taps per accepted sample, then the
// rounded/saturated result is held until the downstream stage takes it.
module fir_filter_mac
   import fir_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 4,
   parameter int OUT_W  = 16,
   parameter int SHIFT  = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic signed [DATA_W-1:0]  x,
   input  logic                      in_valid,
   output logic                      in_ready,
   output logic signed [OUT_W-1:0]   y,
   output logic                      out_valid,
   input  logic                      out_ready,
   input  logic                      coef_we,
   input  logic [$clog2(TAPS)-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0]  coef_data,
   output logic                      coef_err,
   output logic                      sat
);

   localparam int ACC_W = acc_width(DATA_W, COEF_W, TAPS);
   localparam int K_W   = $clog2(TAPS);
   localparam logic [K_W-1:0] K_LAST = K_W'(TAPS - 1);

   state_t                   state_q, state_d;
   logic [K_W-1:0]           k_q, k_d;
   logic signed [DATA_W-1:0] taps_q [TAPS];
   logic signed [DATA_W-1:0] taps_d [TAPS];
   logic signed [COEF_W-1:0] coef_q [TAPS];
   logic signed [COEF_W-1:0] coef_d [TAPS];
   logic signed [OUT_W-1:0]  y_q, y_d;
   logic                     sat_q, sat_d;
   logic                     out_valid_q, out_valid_d;
   logic                     coef_err_q, coef_err_d;

   logic                     accept;
   logic                     mac_en;
   logic                     coef_ok;
   logic signed [ACC_W-1:0]  acc_next;
   rs_t                      rs;

   fir_mac #(
      .A_W   (DATA_W),
      .B_W   (COEF_W),
      .ACC_W (ACC_W)
   ) u_mac (
      .clk      (clk),
      .rst      (rst),
      .clr      (accept),
      .en       (mac_en),
      .a        (taps_q[k_q]),
      .b        (coef_q[k_q]),
      .acc_next (acc_next)
   );

   // Writes land only in an idle cycle that is not also taking a sample.
   always_comb begin
      accept  = (state_q == IDLE) && in_valid;
      mac_en  = (state_q == MAC);
      coef_ok = coef_we && (state_q == IDLE) && !in_valid && (int'(coef_addr) < TAPS);
      rs      = round_sat({{(RS_W - ACC_W){acc_next[ACC_W-1]}}, acc_next}, SHIFT, OUT_W);
   end

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      taps_d      = taps_q;
      coef_d      = coef_q;
      y_d         = y_q;
      sat_d       = sat_q;
      out_valid_d = out_valid_q;
      coef_err_d  = coef_we && !coef_ok;

      if (coef_ok) begin
         coef_d[coef_addr] = coef_data;
      end

      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d   = MAC;
               k_d       = '0;
               taps_d[0] = x;
               for (int i = 1; i < TAPS; i++) begin
                  taps_d[i] = taps_q[i-1];
               end
            end
         end
         MAC: begin
            k_d = k_q + K_W'(1);
            if (k_q == K_LAST) begin
               k_d         = '0;
               state_d     = OUT;
               y_d         = rs.value[OUT_W-1:0];
               sat_d       = rs.sat;
               out_valid_d = 1'b1;
            end
         end
         OUT: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= '0;
         taps_q      <= '{default: '0};
         coef_q      <= '{default: '0};
         y_q         <= '0;
         sat_q       <= 1'b0;
         out_valid_q <= 1'b0;
         coef_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         taps_q      <= taps_d;
         coef_q      <= coef_d;
         y_q         <= y_d;
         sat_q       <= sat_d;
         out_valid_q <= out_valid_d;
         coef_err_q  <= coef_err_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign y         = y_q;
   assign sat       = sat_q;
   assign out_valid = out_valid_q;
   assign coef_err  = coef_err_q;

endmodule

// File: tb/tb_fir_filter_mac.sv
// Bench for fir_filter_mac: directed vectors with hand-computed results plus a
// cycle-level reference model compared against the outputs on every negedge.
module tb_fir_filter_mac;

   localparam int DATA_W = 8;
   localparam int COEF_W = 8;
   localparam int TAPS   = 4;
   localparam int OUT_W  = 16;
   localparam int SHIFT  = 0;

   logic                     clk;
   logic                     rst;
   logic signed [DATA_W-1:0] x;
   logic                     in_valid;
   logic                     in_ready;
   logic signed [OUT_W-1:0]  y;
   logic                     out_valid;
   logic                     out_ready;
   logic                     coef_we;
   logic [1:0]               coef_addr;
   logic signed [COEF_W-1:0] coef_data;
   logic                     coef_err;
   logic                     sat;

   int nChecks = 0;
   int nFails  = 0;

   fir_filter_mac #(
      .DATA_W (DATA_W),
      .COEF_W (COEF_W),
      .TAPS   (TAPS),
      .OUT_W  (OUT_W),
      .SHIFT  (SHIFT)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .x         (x),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .y         (y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .coef_we   (coef_we),
      .coef_addr (coef_addr),
      .coef_data (coef_data),
      .coef_err  (coef_err),
      .sat       (sat)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input longint act, input longint exp);
      nChecks++;
      if (act != exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference model: the last TAPS samples and the coefficient table as plain
   // integers; the result is the dot product, rounded, shifted and clamped.
   int     win   [TAPS];
   int     coefM [TAPS];
   bit     modelLive = 1'b0;
   bit     mInReady, mOutValid, mCoefErr, mSat, pSat;
   longint mY, pY;
   int     mCount;

   function automatic void modelFilter(output longint yv, output bit sv);
      longint acc = 0;
      longint p   = longint'(1) << SHIFT;
      longint hi  = (longint'(1) << (OUT_W - 1)) - 1;
      longint lo  = -(longint'(1) << (OUT_W - 1));
      longint a;
      for (int i = 0; i < TAPS; i++) acc += longint'(win[i]) * longint'(coefM[i]);
      if (p > 1) begin
         a   = acc + p / 2;
         acc = (a - (((a % p) + p) % p)) / p;
      end
      sv = 1'b0;
      yv = acc;
      if (acc > hi) begin yv = hi; sv = 1'b1; end
      if (acc < lo) begin yv = lo; sv = 1'b1; end
   endfunction

   initial begin
      forever begin
         @(negedge clk);
         if (modelLive) begin
            checkOutput("in_ready", in_ready, mInReady);
            checkOutput("out_valid", out_valid, mOutValid);
            checkOutput("coef_err", coef_err, mCoefErr);
            if (mOutValid) begin
               checkOutput("y", y, mY);
               checkOutput("sat", sat, mSat);
            end
         end
         if (rst) begin
            for (int i = 0; i < TAPS; i++) begin win[i] = 0; coefM[i] = 0; end
            mInReady  = 1'b1;
            mOutValid = 1'b0;
            mCoefErr  = 1'b0;
            mSat      = 1'b0;
            mY        = 0;
            mCount    = 0;
            modelLive = 1'b1;
         end else if (modelLive) begin
            mCoefErr = coef_we && !(mInReady && !in_valid);
            if (coef_we && mInReady && !in_valid) coefM[coef_addr] = int'(coef_data);
            if (mInReady && in_valid) begin
               for (int i = TAPS - 1; i > 0; i--) win[i] = win[i-1];
               win[0] = int'(x);
               modelFilter(pY, pSat);
               mInReady = 1'b0;
               mCount   = TAPS;
            end else if (mCount > 0) begin
               mCount--;
               if (mCount == 0) begin
                  mOutValid = 1'b1;
                  mY        = pY;
                  mSat      = pSat;
               end
            end else if (mOutValid && out_ready) begin
               mOutValid = 1'b0;
               mInReady  = 1'b1;
            end
         end
      end
   end

   task automatic writeCoef(input int addr, input int val);
      int i = 0;
      while (!in_ready && i < 20) begin @(posedge clk); #1; i++; end
      coef_we   = 1'b1;
      coef_addr = 2'(addr);
      coef_data = 8'(val);
      @(posedge clk); #1;
      coef_we = 1'b0;
   endtask

   task automatic loadCoefs(input int c0, input int c1, input int c2, input int c3);
      writeCoef(0, c0);
      writeCoef(1, c1);
      writeCoef(2, c2);
      writeCoef(3, c3);
   endtask

   // wrPhase: 0 = no write, 1 = write on the accept edge, 2 = write in first MAC cycle.
   task automatic applyStimulus(input logic signed [7:0] xv, input int wrPhase,
                                input int wa, input int wd,
                                output longint gotY, output logic gotSat);
      bit readySeen = 1'b0;
      bit done      = 1'b0;
      int lat       = 0;
      x        = xv;
      in_valid = 1'b1;
      for (int i = 0; i < 20 && !readySeen; i++) begin
         readySeen = in_ready;
         if (readySeen && wrPhase == 1) begin
            coef_we = 1'b1; coef_addr = 2'(wa); coef_data = 8'(wd);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      coef_we  = 1'b0;
      checkOutput("accept_seen", readySeen, 1);
      if (wrPhase == 1) checkOutput("coef_err_on_accept", coef_err, 1);
      gotY   = 0;
      gotSat = 1'b0;
      while (!done && lat < 20) begin
         if (out_valid) begin
            done   = 1'b1;
            gotY   = y;
            gotSat = sat;
         end else begin
            if (wrPhase == 2 && lat == 0) begin
               coef_we = 1'b1; coef_addr = 2'(wa); coef_data = 8'(wd);
            end
            @(posedge clk); #1;
            lat++;
            if (wrPhase == 2 && lat == 1) begin
               checkOutput("coef_err_in_mac", coef_err, 1);
               coef_we = 1'b0;
            end
         end
      end
      checkOutput("output_seen", done, 1);
      checkOutput("latency", lat, TAPS);
   endtask

   int     impX [5] = '{16, 0, 0, 0, 0};
   int     impE [5] = '{16, 32, 48, 64, 0};
   int     stpX [5] = '{16, 32, 48, 64, 0};
   int     stpE [5] = '{16, 48, 96, 160, 144};
   longint gy;
   logic   gs;
   bit     sawValid;
   int     waitCnt;

   initial begin
      rst = 1'b1; x = '0; in_valid = 1'b0; out_ready = 1'b1;
      coef_we = 1'b0; coef_addr = '0; coef_data = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      checkOutput("reset_in_ready", in_ready, 1);
      checkOutput("reset_out_valid", out_valid, 0);
      checkOutput("reset_y", y, 0);
      checkOutput("reset_sat", sat, 0);
      checkOutput("reset_coef_err", coef_err, 0);

      loadCoefs(1, 2, 3, 4);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'(impX[i]), 0, 0, 0, gy, gs);
         checkOutput($sformatf("impulse_y%0d", i), gy, impE[i]);
      end

      loadCoefs(1, 1, 1, 1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'(stpX[i]), 0, 0, 0, gy, gs);
         checkOutput($sformatf("step_y%0d", i), gy, stpE[i]);
         checkOutput($sformatf("step_sat%0d", i), gs, 0);
      end

      loadCoefs(-128, -128, -128, -128);
      for (int i = 0; i < 4; i++) applyStimulus(-8'sd128, 0, 0, 0, gy, gs);
      checkOutput("satpos_y", gy, 32767);
      checkOutput("satpos_flag", gs, 1);
      applyStimulus(8'sd127, 0, 0, 0, gy, gs);
      checkOutput("satpos127_y", gy, 32767);
      checkOutput("satpos127_flag", gs, 1);

      loadCoefs(127, 127, 127, 127);
      for (int i = 0; i < 4; i++) applyStimulus(-8'sd128, 0, 0, 0, gy, gs);
      checkOutput("satneg_y", gy, -32768);
      checkOutput("satneg_flag", gs, 1);

      loadCoefs(1, 2, 3, 4);
      out_ready = 1'b0;
      applyStimulus(8'sd10, 0, 0, 0, gy, gs);
      checkOutput("bp_y", gy, -1142);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         x        = 8'sd99;
         @(posedge clk); #1;
         checkOutput("bp_hold_y", y, -1142);
         checkOutput("bp_hold_valid", out_valid, 1);
         checkOutput("bp_hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_release_in_ready", in_ready, 1);
      checkOutput("bp_release_valid", out_valid, 0);
      applyStimulus(8'sd0, 0, 0, 0, gy, gs);
      checkOutput("bp_after_y", gy, -876);

      applyStimulus(8'sd1, 2, 0, 5, gy, gs);
      checkOutput("macwrite_old_coef_y", gy, -481);
      writeCoef(0, 5);
      applyStimulus(8'sd2, 0, 0, 0, gy, gs);
      checkOutput("idlewrite_new_coef_y", gy, 52);
      applyStimulus(8'sd3, 1, 1, 9, gy, gs);
      checkOutput("accept_write_dropped_y", gy, 22);

      in_valid = 1'b1;
      x        = 8'sd7;
      waitCnt  = 0;
      while (!in_ready && waitCnt < 20) begin @(posedge clk); #1; waitCnt++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("abort_in_ready", in_ready, 1);
      checkOutput("abort_out_valid", out_valid, 0);
      sawValid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (out_valid) sawValid = 1'b1;
      end
      checkOutput("abort_no_output", sawValid, 0);
      applyStimulus(8'sd20, 0, 0, 0, gy, gs);
      checkOutput("abort_coefs_zero_y", gy, 0);
      loadCoefs(1, 1, 1, 1);
      applyStimulus(8'sd5, 0, 0, 0, gy, gs);
      checkOutput("abort_taps_zero_y", gy, 25);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/fir_filter_mac.md
Name: fir_filter_mac

Overview:
- Parametrised, time-multiplexed FIR filter. It is the successor to the fixed 8-bit direct-form FIR.
- A single multiply-accumulate (MAC) unit iterates over TAPS coefficients per input sample.
- Coefficients are loadable at run time.
- Output has rounding/shift and saturation.
- Input and output use valid/ready handshakes, so the block sits between a sample source and a downstream DSP stage with backpressure.

Parameters:
- DATA_W, 8: signed input sample width.
- COEF_W, 8: signed coefficient width.
- TAPS, 4: number of taps, >=2.
- OUT_W, 16: signed output width.
- SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- x  in  DATA_W  signed input sample.
- in_valid  in  1  x is valid.
- in_ready  out  1  block can accept a sample.
- y  out  OUT_W  signed filtered output.
- out_valid  out  1  y is valid.
- out_ready  in  1  downstream accepts y.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  clog2(TAPS)  tap index to write.
- coef_data  in  COEF_W  signed coefficient value.
- coef_err  out  1  one-cycle pulse: a write was dropped.
- sat  out  1  the current y was saturated; valid while out_valid is high.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; all delay-line taps and all coefficients = 0; accumulator = 0.
  - y=0, out_valid=0, sat=0, coef_err=0; in_ready=1 in the cycle after reset.
  - Reset mid-operation aborts any MAC or OUT in progress; no output is produced for the aborted sample.
- Delay line: tap[0..TAPS-1]. On input accept (in_valid && in_ready at an edge):
  - tap[0] <= x; tap[k] <= tap[k-1] for k>0.
  - Accumulator <= 0, k <= 0, state <= MAC.
- State machine:
  - IDLE: in_ready=1. Exits to MAC on accept.
  - MAC: in_ready=0.
    - Each edge: acc <= acc + tap[k]*coef[k], k <= k+1.
    - After the edge with k=TAPS-1: register y, set out_valid=1, go to OUT.
    - Exactly TAPS edges are spent in MAC; out_valid is first high TAPS edges after the accept edge.
  - OUT: in_ready=0; y, sat and out_valid are held stable.
    - On out_valid && out_ready at an edge: out_valid <= 0, go to IDLE.
    - Minimum sample interval is therefore TAPS+2 cycles.
- Arithmetic:
  - Products are full precision DATA_W+COEF_W.
  - Accumulator width ACC_W = DATA_W+COEF_W+clog2(TAPS); no internal overflow.
  - If SHIFT>0, add 2^(SHIFT-1) before the arithmetic shift (round half up).
  - The shifted value is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; sat=1 when clamping occurred.
- Coefficient writes:
  - Applied only when state=IDLE and not in the same edge as an input accept; coef[coef_addr] <= coef_data.
  - A write in any other state or cycle is dropped and coef_err pulses high for one cycle.
  - coef_addr >= TAPS (non-power-of-2 TAPS) is dropped and also pulses coef_err.
- Simultaneous events: in IDLE with in_valid=1 and coef_we=1 at the same edge, the input is accepted and the write is dropped (coef_err=1).

Decomposition:
- Shared package fir_pkg holds:
  - The state enum {IDLE, MAC, OUT}.
  - A function acc_width(DATA_W, COEF_W, TAPS).
  - A function round_sat(acc, SHIFT, OUT_W) returning the value plus a sat flag.
- One sub-module, fir_mac: registered multiply-accumulate with clear and enable.
- The top level holds the FSM, delay line, coefficient RAM, round/saturate stage and handshakes.

Test Plan:
- Impulse: coefs {1,2,3,4}; inputs 16,0,0,0,0 with out_ready=1 -> y=16,32,48,64,0; out_valid exactly 4 edges after each accept.
- Step: coefs all 1; inputs 16,32,48,64,0 -> y=16,48,96,160,144; sat=0 throughout.
- Saturation: coefs all -128; four inputs of -128 -> accumulator 65536 on the 4th output, so y=32767 and sat=1; then one input of 127 (window 127,-128,-128,-128) -> y=32767, sat=1.
- Backpressure: hold out_ready=0 for 5 cycles in OUT -> y and out_valid stable, in_ready=0 throughout, an offered sample is not accepted; out_ready=1 -> IDLE next cycle.
- Coefficient write during MAC: write coef[0]=5 while busy -> coef_err pulse, coef[0] unchanged, next output uses the old value; the same write in IDLE takes effect.
- Reset at the 2nd MAC cycle -> out_valid never rises for that sample; taps and coefs read 0; in_ready=1 the cycle after reset.
